// File: rtl/sorter_pkg.sv
// Shared constants and FSM state type for the perceptron trainer.
// Parameter defaults for the top level live here.
package sorter_pkg;

  localparam int NUM_IN  = 8;
  localparam int W_WIDTH = 8;
  localparam int THRESH  = 8;
  localparam int INIT_W  = 2;
  localparam int LR      = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    UPDATE
  } state_t;

endpackage

// File: rtl/weight_sat_update.sv
// Saturating +/- LR step for one weight; pure combinational.
// Result clamps at all-ones and at zero instead of wrapping.
module weight_sat_update #(
  parameter int W  = 8,
  parameter int LR = 1
) (
  input  logic         en,
  input  logic         inc,
  input  logic [W-1:0] w,
  output logic [W-1:0] w_nxt
);

  localparam logic [W:0] STEP = (W+1)'(LR);

  logic [W:0] up;
  logic [W:0] down;

  assign up   = {1'b0, w} + STEP;
  assign down = {1'b0, w} - STEP;

  always_comb begin
    w_nxt = w;
    if (en) begin
      if (inc)
        w_nxt = up[W] ? '1 : up[W-1:0];
      else
        w_nxt = down[W] ? '0 : down[W-1:0];
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Serial perceptron with online weight learning (IDLE/ACCUM/UPDATE).
// Define PERCEPTRON_TRAINER_STATS_EN to enable the err_count counter.
module perceptron_trainer #(
  parameter int NUM_IN  = sorter_pkg::NUM_IN,
  parameter int W_WIDTH = sorter_pkg::W_WIDTH,
  parameter int THRESH  = sorter_pkg::THRESH,
  parameter int INIT_W  = sorter_pkg::INIT_W,
  parameter int LR      = sorter_pkg::LR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [NUM_IN-1:0]         sample,
  input  logic                      target,
  input  logic                      learn_en,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic                      pred,
  output logic                      err,
  output logic [NUM_IN*W_WIDTH-1:0] weights,
  output logic [15:0]               err_count
);

  import sorter_pkg::*;

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int SW = W_WIDTH + $clog2(NUM_IN);
  localparam logic [IW-1:0] LAST = IW'(NUM_IN - 1);

  state_t state, state_nxt;

  logic [IW-1:0]      idx;
  logic [SW-1:0]      sum;
  logic [SW-1:0]      sum_nxt;
  logic [NUM_IN-1:0]  smp_q;
  logic               tgt_q;
  logic               learn_q;
  logic               pred_q;
  logic               err_q;
  logic               accept;
  logic               fire;
  logic               upd;
  logic [W_WIDTH-1:0] w     [NUM_IN];
  logic [W_WIDTH-1:0] w_nxt [NUM_IN];

  assign accept  = in_valid && in_ready;
  assign sum_nxt = sum + (smp_q[idx] ? SW'(w[idx]) : '0);
  assign fire    = sum_nxt >= SW'(THRESH);
  assign upd     = (state == UPDATE) && learn_q && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = ACCUM;
      end
      ACCUM:
        if (idx == LAST)
          state_nxt = UPDATE;
      UPDATE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      sum     <= '0;
      smp_q   <= '0;
      tgt_q   <= 1'b0;
      learn_q <= 1'b0;
      pred_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      sum     <= '0;
      smp_q   <= sample;
      tgt_q   <= target;
      learn_q <= learn_en;
    end else if (state == ACCUM) begin
      sum <= sum_nxt;
      idx <= idx + 1'b1;
      // decision is latched as the last term goes in
      if (idx == LAST) begin
        pred_q <= fire;
        err_q  <= fire ^ tgt_q;
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_w
    weight_sat_update #(
      .W  (W_WIDTH),
      .LR (LR)
    ) u_upd (
      .en    (upd && smp_q[i]),
      .inc   (tgt_q),
      .w     (w[i]),
      .w_nxt (w_nxt[i])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        w[i] <= W_WIDTH'(INIT_W);
      else
        w[i] <= w_nxt[i];
    end

    assign weights[i*W_WIDTH +: W_WIDTH] = w[i];
  end

  assign out_valid = (state == UPDATE);
  assign pred      = pred_q;
  assign err       = err_q;

`ifdef PERCEPTRON_TRAINER_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (out_valid && err_q && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign err_count = cnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer plus two threshold/step variants.
// Expected values are hand-computed constants.
module tb_perceptron_trainer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  sample = '0;
  logic        target = 1'b0;
  logic        learn_en = 1'b0;

  logic        in_ready, out_valid, pred, err;
  logic [63:0] weights;
  logic [15:0] err_count;

  logic        in_ready_hi, out_valid_hi, pred_hi, err_hi;
  logic [63:0] weights_hi;
  logic [15:0] err_count_hi;

  logic        in_ready_lo, out_valid_lo, pred_lo, err_lo;
  logic [63:0] weights_lo;
  logic [15:0] err_count_lo;

  int n_chk = 0;
  int n_fail = 0;

  int   obs_lat;
  logic obs_pred;
  logic obs_err;

`ifdef PERCEPTRON_TRAINER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  perceptron_trainer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sample    (sample),
    .target    (target),
    .learn_en  (learn_en),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .pred      (pred),
    .err       (err),
    .weights   (weights),
    .err_count (err_count)
  );

  // never fires: every error with target=1 pushes weights up by 4
  perceptron_trainer #(.THRESH(2047), .LR(4)) dut_hi (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sample    (sample),
    .target    (target),
    .learn_en  (learn_en),
    .in_ready  (in_ready_hi),
    .out_valid (out_valid_hi),
    .pred      (pred_hi),
    .err       (err_hi),
    .weights   (weights_hi),
    .err_count (err_count_hi)
  );

  // always fires: every error with target=0 pulls weights down by 3
  perceptron_trainer #(.THRESH(0), .LR(3)) dut_lo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sample    (sample),
    .target    (target),
    .learn_en  (learn_en),
    .in_ready  (in_ready_lo),
    .out_valid (out_valid_lo),
    .pred      (pred_lo),
    .err       (err_lo),
    .weights   (weights_lo),
    .err_count (err_count_lo)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] s, input logic t, input logic l);
    int cyc;
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready)
      check("ready_wait", 64'(in_ready), 64'd1);
    sample = s;
    target = t;
    learn_en = l;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sample = ~s;
    target = ~t;
    learn_en = ~l;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    obs_lat = cyc;
    obs_pred = pred;
    obs_err = err;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, busy, first, second;
    logic ov;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pred", 64'(pred), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_w", weights, 64'h0202020202020202);
    check("rst_cnt", 64'(err_count), 64'd0);

    send(8'hFF, 1'b0, 1'b1);
    check("ff_lat", 64'(obs_lat), 64'd9);
    check("ff_pred", 64'(obs_pred), 64'd1);
    check("ff_err", 64'(obs_err), 64'd1);
    check("ff_w", weights, 64'h0101010101010101);
    check("ff_cnt", 64'(err_count), STATS ? 64'd1 : 64'd0);
    check("ff_ovlow", 64'(out_valid), 64'd0);
    check("ff_hold", 64'(pred), 64'd1);

    do_reset();
    send(8'h01, 1'b1, 1'b1);
    check("b0_lat", 64'(obs_lat), 64'd9);
    check("b0_pred", 64'(obs_pred), 64'd0);
    check("b0_err", 64'(obs_err), 64'd1);
    check("b0_w", weights, 64'h0202020202020203);

    do_reset();
    send(8'hFF, 1'b0, 1'b0);
    check("nl_pred", 64'(obs_pred), 64'd1);
    check("nl_err", 64'(obs_err), 64'd1);
    check("nl_w", weights, 64'h0202020202020202);
    check("nl_cnt", 64'(err_count), STATS ? 64'd1 : 64'd0);

    do_reset();
    for (int i = 0; i < 63; i++)
      send(8'h01, 1'b1, 1'b1);
    check("hi_254", weights_hi, 64'h02020202020202FE);
    send(8'h01, 1'b1, 1'b1);
    check("hi_sat", weights_hi, 64'h02020202020202FF);
    send(8'h01, 1'b1, 1'b1);
    check("hi_hold", weights_hi, 64'h02020202020202FF);
    check("hi_cnt", 64'(err_count_hi), STATS ? 64'd65 : 64'd0);
    check("lo_keep", weights_lo, 64'h0202020202020202);
    send(8'h02, 1'b0, 1'b1);
    check("lo_zero", weights_lo, 64'h0202020202020002);
    send(8'h02, 1'b0, 1'b1);
    check("lo_hold", weights_lo, 64'h0202020202020002);
    check("lo_cnt", 64'(err_count_lo), STATS ? 64'd2 : 64'd0);

    do_reset();
    @(negedge clk);
    sample = 8'h00;
    target = 1'b0;
    learn_en = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    busy = 0;
    first = -1;
    second = -1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        acc++;
        if (first < 0)
          first = i;
        else if (second < 0)
          second = i;
      end else begin
        busy++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bb_acc", 64'(acc), 64'd5);
    check("bb_gap", 64'(second - first), 64'd10);
    check("bb_busy", 64'(busy), 64'd45);
    repeat (12) @(negedge clk);

    do_reset();
    @(negedge clk);
    sample = 8'hFF;
    target = 1'b0;
    learn_en = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ov = ov | out_valid;
    end
    check("ar_noval", 64'(ov), 64'd0);
    check("ar_w", weights, 64'h0202020202020202);
    check("ar_ready2", 64'(in_ready), 64'd1);
    send(8'h01, 1'b1, 1'b1);
    check("ar_lat", 64'(obs_lat), 64'd9);
    check("ar_pred", 64'(obs_pred), 64'd0);
    check("ar_err", 64'(obs_err), 64'd1);
    check("ar_w2", weights, 64'h0202020202020203);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL provide parameter NUM_IN, default 8, number of binary perceptron inputs.
REQ-002 SHALL provide parameter W_WIDTH, default 8, unsigned weight width.
REQ-003 SHALL provide parameter THRESH, default 8, firing threshold (fires when sum >= THRESH).
REQ-004 SHALL provide parameter INIT_W, default 2, reset value of every weight.
REQ-005 SHALL provide parameter LR, default 1, learning step added to or subtracted from a weight.
REQ-006 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-007 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports: in_valid  input  1  sample offered; sample  input  NUM_IN  input vector; target  input  1  desired output.
REQ-009 SHALL have ports: learn_en  input  1  weight update enable, sampled at handshake.
REQ-010 SHALL have ports: in_ready  output  1  idle, can accept a sample.
REQ-011 SHALL have ports: out_valid  output  1  one-cycle result strobe; pred  output  1  perceptron decision; err  output  1  pred != target.
REQ-012 SHALL have ports: weights  output  NUM_IN*W_WIDTH  flat weight bank, weight i at bits [i*W_WIDTH +: W_WIDTH].
REQ-013 SHALL have ports: err_count  output  16  misclassification counter.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, UPDATE.
REQ-015 Handshake: sample, target and learn_en SHALL be captured on the rising edge where in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-016 In ACCUM, SHALL run NUM_IN cycles, index 0..NUM_IN-1, adding weight[idx] to the sum when captured sample[idx]=1.
REQ-017 The sum register SHALL be W_WIDTH+$clog2(NUM_IN) bits wide, cleared on entry to ACCUM, and SHALL never overflow.
REQ-018 After index NUM_IN-1, SHALL enter UPDATE for exactly one cycle, then return to IDLE.
REQ-019 In UPDATE, SHALL assert out_valid with pred = (sum >= THRESH) and err = pred ^ target.
REQ-020 Latency: out_valid SHALL be high in cycle NUM_IN+1 after the acceptance edge, i.e. 9 cycles for NUM_IN=8; throughput SHALL be one sample per NUM_IN+2 cycles.
REQ-021 Learning, at the end of the UPDATE cycle when learn_en was captured as 1 and err=1: each weight with sample bit 1 SHALL be increased by LR if target=1, or decreased by LR if target=0; weights with sample bit 0 SHALL be unchanged.
REQ-022 Weight arithmetic SHALL saturate at 2^W_WIDTH-1 and at 0; there SHALL be no wrap-around.
REQ-023 Updated weights SHALL be visible on the weights port from the cycle after UPDATE.
REQ-024 in_valid outside IDLE SHALL be ignored; input changes after capture SHALL not affect the result in progress.
REQ-025 Outside UPDATE, pred and err SHALL hold their last values; out_valid SHALL be 0.

Reset
REQ-026 With rst_n=0, regardless of state, the FSM SHALL return immediately to IDLE, all weights SHALL become INIT_W, and sum, pred, err, out_valid and err_count SHALL become 0; in_ready SHALL be 1 after reset.
REQ-027 A sample in progress when reset is asserted SHALL be discarded, with no out_valid and no weight change.

Configuration
REQ-028 Macro PERCEPTRON_TRAINER_STATS_EN: when defined, err_count SHALL increment on every out_valid with err=1 and saturate at 16'hFFFF.
REQ-029 When PERCEPTRON_TRAINER_STATS_EN is undefined, err_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-030 Shared package sorter_pkg SHALL hold the FSM state typedef, NUM_IN, W_WIDTH and the default THRESH, INIT_W and LR constants.
REQ-031 Saturating add/subtract SHALL be implemented as sub-module weight_sat_update, instantiated once per weight.

Verification
REQ-032 Reset, then sample=8'hFF, target=0, learn_en=1: out_valid 9 cycles after acceptance, pred=1 (sum 16), err=1, all weights 1 afterwards.
REQ-033 After reset, sample=8'h01, target=1, learn_en=1: pred=0 (sum 2), err=1, weight0=3, others 2.
REQ-034 Same as REQ-032 but learn_en=0: pred=1, err=1, weights unchanged at 2; err_count=1 with macro defined, 0 without.
REQ-035 Drive weight0 to 255 by repeated sample=8'h01, target=1: weight0 stays 255 and does not wrap; drive a weight to 0 with target=0: it stays 0.
REQ-036 Hold in_valid high continuously: exactly one acceptance per 10 cycles, and in_ready=0 throughout ACCUM and UPDATE.
REQ-037 Assert rst_n=0 at ACCUM index 4: no out_valid, weights=2, in_ready=1 after release, and the next sample processes normally.
